// File: rtl/requant_pkg.sv
// Shared constants and helpers for the per-channel requantizer.
package requant_pkg;

  localparam int DEF_MULT_C  = 116;
  localparam int DEF_SHIFT_C = 16;
  localparam int DEF_BIAS_C  = 0;

  // Channel index width; a single-channel build still gets a 1-bit index.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Largest signed value representable in w bits.
  function automatic int out_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Most negative signed value representable in w bits.
  function automatic int out_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/requant_cfg_table.sv
// Per-channel bias/multiplier/shift register file.
// Synchronous write and combinational read. A read and a write to the same
// entry in one cycle returns the old contents. Writes to indices beyond
// NUM_CH-1 are dropped.
module requant_cfg_table
  import requant_pkg::*;
#(
  parameter int NUM_CH    = 16,
  parameter int MULT_W    = 16,
  parameter int SHIFT_W   = 6,
  parameter int BIAS_W    = 32,
  parameter int DEF_MULT  = DEF_MULT_C,
  parameter int DEF_SHIFT = DEF_SHIFT_C,
  localparam int CH_W     = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [MULT_W-1:0]        wr_mult,
  input  logic [SHIFT_W-1:0]       wr_shift,
  input  logic signed [BIAS_W-1:0] wr_bias,
  input  logic [CH_W-1:0]          rd_ch,
  output logic [MULT_W-1:0]        rd_mult,
  output logic [SHIFT_W-1:0]       rd_shift,
  output logic signed [BIAS_W-1:0] rd_bias
);

  logic [MULT_W-1:0]        mult_q  [NUM_CH];
  logic [MULT_W-1:0]        mult_d  [NUM_CH];
  logic [SHIFT_W-1:0]       shift_q [NUM_CH];
  logic [SHIFT_W-1:0]       shift_d [NUM_CH];
  logic signed [BIAS_W-1:0] bias_q  [NUM_CH];
  logic signed [BIAS_W-1:0] bias_d  [NUM_CH];

  // Next-state of the table: copy, then overwrite the addressed entry.
  always_comb begin
    mult_d  = mult_q;
    shift_d = shift_q;
    bias_d  = bias_q;
    if (we && (int'(wr_ch) < NUM_CH)) begin
      mult_d[wr_ch]  = wr_mult;
      shift_d[wr_ch] = wr_shift;
      bias_d[wr_ch]  = wr_bias;
    end
  end

  // Table storage, reset to the default requant parameters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mult_q[i]  <= MULT_W'(DEF_MULT);
        shift_q[i] <= SHIFT_W'(DEF_SHIFT);
        bias_q[i]  <= BIAS_W'(DEF_BIAS_C);
      end
    end else begin
      mult_q  <= mult_d;
      shift_q <= shift_d;
      bias_q  <= bias_d;
    end
  end

  // Combinational read port used by the first pipeline stage.
  always_comb begin
    rd_mult  = mult_q[rd_ch];
    rd_shift = shift_q[rd_ch];
    rd_bias  = bias_q[rd_ch];
  end

endmodule

// File: rtl/requant_pipe.sv
// Per-channel requantizer: IN_W-bit accumulators -> OUT_W-bit activations.
//   S1: add channel bias, latch channel mult/shift
//   S2: multiply by unsigned channel multiplier
//   S3: round-half-up shift, add zero point, saturate
// All stages advance together on en = !out_valid || out_ready.
// Build option REQUANT_RELU_EN raises the lower clamp bound to ZERO_POINT.
module requant_pipe
  import requant_pkg::*;
#(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 8,
  parameter int MULT_W     = 16,
  parameter int SHIFT_W    = 6,
  parameter int BIAS_W     = 32,
  parameter int NUM_CH     = 16,
  parameter int DEF_MULT   = DEF_MULT_C,
  parameter int DEF_SHIFT  = DEF_SHIFT_C,
  parameter int ZERO_POINT = 0,
  localparam int CH_W      = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IN_W-1:0]   in_data,
  input  logic                     in_first,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [MULT_W-1:0]        cfg_mult,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic signed [BIAS_W-1:0] cfg_bias,
  output logic [15:0]              sat_cnt
);

  localparam int SUM_W = IN_W + 1;
  localparam int PW    = IN_W + MULT_W + 2;

  localparam logic signed [PW:0]   RND_ONE = 1;
  localparam logic signed [PW+1:0] ZP_W    = (PW+2)'(ZERO_POINT);
  localparam logic signed [PW+1:0] HI_W    = (PW+2)'(out_max(OUT_W));
`ifdef REQUANT_RELU_EN
  localparam logic signed [PW+1:0] LO_W    = ZP_W;
`else
  localparam logic signed [PW+1:0] LO_W    = (PW+2)'(out_min(OUT_W));
`endif

  logic                     en;
  logic                     accept;
  logic [CH_W-1:0]          acc_ch;

  logic [MULT_W-1:0]        tbl_mult;
  logic [SHIFT_W-1:0]       tbl_shift;
  logic signed [BIAS_W-1:0] tbl_bias;

  logic [CH_W-1:0]          ctr_q, ctr_d;

  logic                     v1_q, v1_d;
  logic signed [SUM_W-1:0]  sum1_q, sum1_d;
  logic [MULT_W-1:0]        mult1_q, mult1_d;
  logic [SHIFT_W-1:0]       shift1_q, shift1_d;
  logic [CH_W-1:0]          ch1_q, ch1_d;

  logic                     v2_q, v2_d;
  logic signed [PW-1:0]     prod2_q, prod2_d;
  logic [SHIFT_W-1:0]       shift2_q, shift2_d;
  logic [CH_W-1:0]          ch2_q, ch2_d;

  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic [CH_W-1:0]          out_ch_q, out_ch_d;
  logic                     out_sat_q, out_sat_d;
  logic [15:0]              sat_cnt_q, sat_cnt_d;

  logic signed [PW:0]       rnd_w;
  logic signed [PW:0]       r_w;
  logic signed [PW+1:0]     v_w;
  logic signed [OUT_W-1:0]  clamp_w;
  logic                     sat_w;

  requant_cfg_table #(
    .NUM_CH    (NUM_CH),
    .MULT_W    (MULT_W),
    .SHIFT_W   (SHIFT_W),
    .BIAS_W    (BIAS_W),
    .DEF_MULT  (DEF_MULT),
    .DEF_SHIFT (DEF_SHIFT)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (cfg_we),
    .wr_ch    (cfg_ch),
    .wr_mult  (cfg_mult),
    .wr_shift (cfg_shift),
    .wr_bias  (cfg_bias),
    .rd_ch    (acc_ch),
    .rd_mult  (tbl_mult),
    .rd_shift (tbl_shift),
    .rd_bias  (tbl_bias)
  );

  // S3 arithmetic: round half toward +inf, add zero point, saturate on full width.
  always_comb begin
    rnd_w = '0;
    if (shift2_q != '0) begin
      rnd_w = RND_ONE << (shift2_q - SHIFT_W'(1));
    end
    r_w     = ((PW+1)'(prod2_q) + rnd_w) >>> shift2_q;
    v_w     = (PW+2)'(r_w) + ZP_W;
    sat_w   = 1'b0;
    clamp_w = v_w[OUT_W-1:0];
    if (v_w > HI_W) begin
      sat_w   = 1'b1;
      clamp_w = HI_W[OUT_W-1:0];
    end else if (v_w < LO_W) begin
      sat_w   = 1'b1;
      clamp_w = LO_W[OUT_W-1:0];
    end
  end

  // Handshake, channel counter and next-state of every pipeline stage.
  always_comb begin
    en     = !out_valid_q || out_ready;
    accept = in_valid && en;
    acc_ch = in_first ? '0 : ctr_q;

    ctr_d       = ctr_q;
    v1_d        = v1_q;
    sum1_d      = sum1_q;
    mult1_d     = mult1_q;
    shift1_d    = shift1_q;
    ch1_d       = ch1_q;
    v2_d        = v2_q;
    prod2_d     = prod2_q;
    shift2_d    = shift2_q;
    ch2_d       = ch2_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_sat_d   = out_sat_q;
    sat_cnt_d   = sat_cnt_q;

    if (accept) begin
      ctr_d = (int'(acc_ch) == NUM_CH - 1) ? '0 : acc_ch + CH_W'(1);
    end

    if (en) begin
      v1_d = in_valid;
      if (in_valid) begin
        sum1_d   = SUM_W'(in_data) + SUM_W'(tbl_bias);
        mult1_d  = tbl_mult;
        shift1_d = tbl_shift;
        ch1_d    = acc_ch;
      end
      v2_d = v1_q;
      if (v1_q) begin
        prod2_d  = PW'(sum1_q) * PW'($signed({1'b0, mult1_q}));
        shift2_d = shift1_q;
        ch2_d    = ch1_q;
      end
      out_valid_d = v2_q;
      if (v2_q) begin
        out_data_d = clamp_w;
        out_ch_d   = ch2_q;
        out_sat_d  = sat_w;
      end
    end

    if (out_valid_q && out_ready && out_sat_q && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  // Pipeline registers; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q       <= '0;
      v1_q        <= 1'b0;
      sum1_q      <= '0;
      mult1_q     <= '0;
      shift1_q    <= '0;
      ch1_q       <= '0;
      v2_q        <= 1'b0;
      prod2_q     <= '0;
      shift2_q    <= '0;
      ch2_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_sat_q   <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      ctr_q       <= ctr_d;
      v1_q        <= v1_d;
      sum1_q      <= sum1_d;
      mult1_q     <= mult1_d;
      shift1_q    <= shift1_d;
      ch1_q       <= ch1_d;
      v2_q        <= v2_d;
      prod2_q     <= prod2_d;
      shift2_q    <= shift2_d;
      ch2_q       <= ch2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_sat_q   <= out_sat_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign sat_cnt   = sat_cnt_q;

endmodule
